// File: rtl/rotary_encoder_adjust_if.sv
// Encoder-side signal bundle for rotary_encoder_adjust: raw encoder lines in,
// adjust pulses and the minutes/hours select out.
interface rotary_encoder_adjust_if;
  logic i_Enc_A;
  logic i_Enc_B;
  logic i_Enc_Sw;
  logic o_Minutes_Inc;
  logic o_Minutes_Dec;
  logic o_Hours_Inc;
  logic o_Hours_Dec;
  logic o_Hours_Sel;

  // Environment side: drives the encoder, observes the adjust pulses.
  modport master (
    output i_Enc_A, i_Enc_B, i_Enc_Sw,
    input  o_Minutes_Inc, o_Minutes_Dec, o_Hours_Inc, o_Hours_Dec, o_Hours_Sel
  );

  // Front-end side: receives the encoder, produces the adjust pulses.
  modport slave (
    input  i_Enc_A, i_Enc_B, i_Enc_Sw,
    output o_Minutes_Inc, o_Minutes_Dec, o_Hours_Inc, o_Hours_Dec, o_Hours_Sel
  );
endinterface

// File: rtl/rotary_encoder_adjust.sv
// Quadrature rotary-encoder front end for the time/alarm adjust path.
// Synchronises and debounces A/B/Sw, decodes quadrature steps into a signed
// accumulator and emits one single-cycle inc/dec pulse per detent, routed to
// the minutes or hours pair by a push-switch toggle.
module rotary_encoder_adjust #(
  parameter int SAMPLE_DIV       = 5000,
  parameter int FILTER_LEN       = 4,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  rotary_encoder_adjust_if.slave  enc
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ACC_W = $clog2(STEPS_PER_DETENT + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_PER_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] STEP_POS = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] STEP_NEG = {ACC_W{1'b1}};
  localparam logic signed [ACC_W-1:0] STEP_NONE = {ACC_W{1'b0}};

  // Bit order in the 3-bit vectors: [0] = A, [1] = B, [2] = Sw.
  logic [2:0]                 raw;
  logic [2:0]                 sync_1;
  logic [2:0]                 sync_2;
  logic [CNT_W-1:0]           count;
  logic                       tick;
  logic [2:0][FILTER_LEN-1:0] hist;
  logic [2:0][FILTER_LEN-1:0] hist_next;
  logic [2:0]                 filt;
  logic [2:0]                 filt_next;
  logic                       sw_prev;
  logic                       sw_rise;
  logic [1:0]                 prev_ab;
  logic [1:0]                 cur_ab;
  logic                       ab_changed;
  logic                       illegal;
  logic signed [ACC_W-1:0]    step_dir;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    acc_next;
  logic                       det_inc;
  logic                       det_dec;
  logic                       hours_sel;
  logic                       min_inc;
  logic                       min_dec;
  logic                       hr_inc;
  logic                       hr_dec;

  assign raw    = {enc.i_Enc_Sw, enc.i_Enc_B, enc.i_Enc_A};
  assign tick   = (count == CNT_LAST);
  assign cur_ab = {filt[0], filt[1]};
  assign sw_rise = filt[2] & ~sw_prev;

  // Two-flop synchroniser for each raw encoder line.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync_1 <= 3'b000;
      sync_2 <= 3'b000;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Sample prescaler: free-running 0..SAMPLE_DIV-1.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Next filter history and level: a level is adopted only once the whole history agrees.
  always_comb begin
    hist_next = hist;
    filt_next = filt;
    for (int i = 0; i < 3; i++) begin
      hist_next[i] = {hist[i][FILTER_LEN-2:0], sync_2[i]};
      if (&hist_next[i]) begin
        filt_next[i] = 1'b1;
      end else if (~|hist_next[i]) begin
        filt_next[i] = 1'b0;
      end else begin
        filt_next[i] = filt[i];
      end
    end
  end

  // Filter state advances only on sample ticks, so filtered levels change only then.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hist <= '0;
      filt <= 3'b000;
    end else if (tick) begin
      hist <= hist_next;
      filt <= filt_next;
    end else begin
      hist <= hist;
      filt <= filt;
    end
  end

  // Quadrature step direction from previous/current filtered AB; diagonal jumps are illegal.
  always_comb begin
    step_dir = STEP_NONE;
    illegal  = ((prev_ab ^ cur_ab) == 2'b11);
    case ({prev_ab, cur_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dir = STEP_POS;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dir = STEP_NEG;
      default:                                step_dir = STEP_NONE;
    endcase
  end

  assign ab_changed = (cur_ab != prev_ab);
  assign acc_sum    = acc + step_dir;

  // Step accumulator update and detent detection; reversals count back toward zero.
  always_comb begin
    acc_next = acc;
    det_inc  = 1'b0;
    det_dec  = 1'b0;
    if (!ab_changed) begin
      acc_next = acc;
    end else if (illegal) begin
      acc_next = STEP_NONE;
    end else if (acc_sum == ACC_MAX) begin
      acc_next = STEP_NONE;
      det_inc  = 1'b1;
    end else if (acc_sum == ACC_MIN) begin
      acc_next = STEP_NONE;
      det_dec  = 1'b1;
    end else begin
      acc_next = acc_sum;
    end
  end

  // Decoder state: previous AB, accumulator and delayed filtered switch.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      prev_ab <= 2'b00;
      acc     <= STEP_NONE;
      sw_prev <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      acc     <= acc_next;
      sw_prev <= filt[2];
    end
  end

  // Registered pulses routed by the pre-toggle select; select toggles on switch press.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hours_sel <= 1'b0;
      min_inc   <= 1'b0;
      min_dec   <= 1'b0;
      hr_inc    <= 1'b0;
      hr_dec    <= 1'b0;
    end else begin
      hours_sel <= hours_sel ^ sw_rise;
      min_inc   <= det_inc & ~hours_sel;
      min_dec   <= det_dec & ~hours_sel;
      hr_inc    <= det_inc & hours_sel;
      hr_dec    <= det_dec & hours_sel;
    end
  end

  assign enc.o_Minutes_Inc = min_inc;
  assign enc.o_Minutes_Dec = min_dec;
  assign enc.o_Hours_Inc   = hr_inc;
  assign enc.o_Hours_Dec   = hr_dec;
  assign enc.o_Hours_Sel   = hours_sel;

endmodule

// File: tb/tb_rotary_encoder_adjust.sv
// Scoreboard bench for rotary_encoder_adjust: stimulus pushes the expected
// pulse code before the step that completes a detent; a monitor pops and
// compares whenever any pulse output is high.
module tb_rotary_encoder_adjust;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_q[$];

  // Pulse codes: 0 minutes inc, 1 minutes dec, 2 hours inc, 3 hours dec.
  localparam int MIN_INC = 0;
  localparam int MIN_DEC = 1;
  localparam int HR_INC  = 2;

  rotary_encoder_adjust_if bus();

  rotary_encoder_adjust #(
    .SAMPLE_DIV(4),
    .FILTER_LEN(3),
    .STEPS_PER_DETENT(4)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .enc(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int hold);
    bus.i_Enc_A = ab[1];
    bus.i_Enc_B = ab[0];
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic press_sw();
    bus.i_Enc_Sw = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.i_Enc_Sw = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Full clockwise detent; the expected code is queued just before the final step.
  task automatic cw_detent(input int code);
    drive_ab(2'b10, 20);
    drive_ab(2'b11, 20);
    drive_ab(2'b01, 20);
    exp_q.push_back(code);
    drive_ab(2'b00, 30);
  endtask

  // Monitor: pops one expectation per observed pulse cycle.
  always @(negedge clk) begin
    logic [3:0] p;
    int code;
    if (!rst) begin
      p = {bus.o_Hours_Dec, bus.o_Hours_Inc, bus.o_Minutes_Dec, bus.o_Minutes_Inc};
      if (p != 4'b0000) begin
        compared++;
        code = (p[0] ? 0 : 0) + (p[1] ? 1 : 0) + (p[2] ? 2 : 0) + (p[3] ? 3 : 0);
        if ($countones(p) != 1) begin
          mismatched++;
          $display("FAIL pulse_onehot: got %b expected exactly one bit", p);
        end else if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse: got code %0d expected none", code);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (e != code) begin
            mismatched++;
            $display("FAIL pulse_code: got %0d expected %0d", code, e);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_Enc_A  = 1'b0;
    bus.i_Enc_B  = 1'b0;
    bus.i_Enc_Sw = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_min_inc", int'(bus.o_Minutes_Inc), 0);
    check("rst_min_dec", int'(bus.o_Minutes_Dec), 0);
    check("rst_hr_inc",  int'(bus.o_Hours_Inc), 0);
    check("rst_hr_dec",  int'(bus.o_Hours_Dec), 0);
    check("rst_sel",     int'(bus.o_Hours_Sel), 0);
    drive_ab(2'b00, 20);

    // Clockwise detent -> one minutes inc.
    cw_detent(MIN_INC);
    check("cw_min_done", exp_q.size(), 0);

    // Counter-clockwise detent -> one minutes dec.
    drive_ab(2'b01, 20);
    drive_ab(2'b11, 20);
    drive_ab(2'b10, 20);
    exp_q.push_back(MIN_DEC);
    drive_ab(2'b00, 30);
    check("ccw_min_done", exp_q.size(), 0);

    // Switch press toggles to hours; release does nothing.
    bus.i_Enc_Sw = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("sel_after_press", int'(bus.o_Hours_Sel), 1);
    bus.i_Enc_Sw = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("sel_after_release", int'(bus.o_Hours_Sel), 1);
    cw_detent(HR_INC);
    check("cw_hr_done", exp_q.size(), 0);
    press_sw();
    check("sel_second_press", int'(bus.o_Hours_Sel), 0);

    // Short glitch on A and a partial rotation that returns: no pulses.
    bus.i_Enc_A = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_ab(2'b00, 20);
    drive_ab(2'b10, 20);
    drive_ab(2'b00, 30);
    check("glitch_no_pulse", exp_q.size(), 0);
    cw_detent(MIN_INC);
    check("after_glitch_inc", exp_q.size(), 0);

    // Illegal jump mid-detent clears the accumulator; full detent after it.
    drive_ab(2'b10, 20);
    drive_ab(2'b11, 20);
    drive_ab(2'b00, 30);
    check("illegal_no_pulse", exp_q.size(), 0);
    cw_detent(MIN_INC);
    check("after_illegal_inc", exp_q.size(), 0);

    // Reset mid-detent while hours selected: outputs clear at once, no pulse after.
    press_sw();
    check("sel_before_reset", int'(bus.o_Hours_Sel), 1);
    drive_ab(2'b10, 20);
    drive_ab(2'b11, 20);
    drive_ab(2'b01, 20);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sel",    int'(bus.o_Hours_Sel), 0);
    check("async_rst_pulses", int'({bus.o_Hours_Dec, bus.o_Hours_Inc,
                                    bus.o_Minutes_Dec, bus.o_Minutes_Inc}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    drive_ab(2'b00, 40);
    check("post_reset_no_pulse", exp_q.size(), 0);
    check("post_reset_sel", int'(bus.o_Hours_Sel), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
